// File: rtl/lfsr_rng_arbiter.sv
// lfsr_rng_arbiter
// Shares one 17-bit Fibonacci LFSR (x^17 + x^14 + 1) between NREQ requesters.
// Each grant delivers a fresh WORD_BITS-bit word built from consecutive
// feedback bits, first bit in the MSB. Requesters are served round-robin.
// A reseed port reloads the LFSR at run time and takes priority over requests.
//
// Ports:
//   clk           clock, rising edge
//   rst_n         synchronous, active-low reset
//   req           per-requester request level, held until own gnt bit
//   reseed_valid  reseed request, held until reseed_ready
//   reseed_data   new LFSR state (zero is replaced by SEED)
//   reseed_ready  one-cycle pulse: reseed applied
//   gnt           one-hot grant pulse, coincident with rnd_valid
//   rnd_valid     one-cycle pulse: rnd_data valid
//   rnd_data      random word, holds between grants
//   busy          high whenever the FSM is not idle
//   wrap_tick     one-cycle pulse: a shift has just returned the LFSR to SEED
module lfsr_rng_arbiter #(
  parameter int          NREQ      = 4,
  parameter int          WORD_BITS = 8,
  parameter logic [16:0] SEED      = 17'h0002B
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic                 reseed_valid,
  input  logic [16:0]          reseed_data,
  output logic                 reseed_ready,
  output logic [NREQ-1:0]      gnt,
  output logic                 rnd_valid,
  output logic [WORD_BITS-1:0] rnd_data,
  output logic                 busy,
  output logic                 wrap_tick
);

  localparam int CNT_W = $clog2(WORD_BITS + 1);
  localparam int IDX_W = $clog2(NREQ);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WORD_BITS - 1);
  localparam logic [IDX_W:0]   NREQ_EXT  = (IDX_W + 1)'(NREQ);

  typedef enum logic [1:0] {IDLE, SHIFT, DELIVER, RESEED} state_t;

  state_t               state, state_next;
  logic [16:0]          lfsr;
  logic [16:0]          lfsr_step;
  logic                 fb;
  logic [WORD_BITS-1:0] acc;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     ptr, idx, winner;
  logic [IDX_W:0]       cand, win_sel;
  logic [2*NREQ-1:0]    req_dbl;
  logic                 any_req;
  logic                 last_step;

  // Shift one bit into the LSB of a word; written via a wider temporary so
  // it also works for WORD_BITS == 1.
  function automatic logic [WORD_BITS-1:0] shift_in(input logic [WORD_BITS-1:0] a,
                                                    input logic b);
    logic [WORD_BITS:0] t;
    t = {a, b};
    return t[WORD_BITS-1:0];
  endfunction

  assign fb        = lfsr[16] ^ lfsr[13];
  assign lfsr_step = {lfsr[15:0], fb};
  assign last_step = (cnt == LAST_STEP);

  // Round-robin search: doubling the request vector lets ptr+offset index it
  // without a modulo; the winner is folded back into 0..NREQ-1 afterwards.
  // Scanning offsets downward leaves the smallest offset from ptr as winner.
  assign req_dbl = {req, req};

  always_comb begin
    cand    = '0;
    win_sel = '0;
    any_req = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      cand = {1'b0, ptr} + (IDX_W + 1)'(j);
      if (req_dbl[cand]) begin
        any_req = 1'b1;
        win_sel = cand;
      end
    end
    winner = (win_sel >= NREQ_EXT) ? IDX_W'(win_sel - NREQ_EXT) : win_sel[IDX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (reseed_valid) state_next = RESEED;
        else if (any_req) state_next = SHIFT;
      end
      SHIFT:   if (last_step) state_next = DELIVER;
      DELIVER: state_next = IDLE;
      RESEED:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs. Output pulses are set on the edge that
  // enters DELIVER/RESEED so they are high exactly during those states.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr         <= SEED;
      acc          <= '0;
      cnt          <= '0;
      ptr          <= '0;
      idx          <= '0;
      gnt          <= '0;
      rnd_valid    <= 1'b0;
      rnd_data     <= '0;
      reseed_ready <= 1'b0;
      busy         <= 1'b0;
      wrap_tick    <= 1'b0;
    end else begin
      gnt          <= '0;
      rnd_valid    <= 1'b0;
      reseed_ready <= 1'b0;
      wrap_tick    <= 1'b0;
      busy         <= (state_next != IDLE);
      case (state)
        IDLE: begin
          cnt <= '0;
          if (reseed_valid)  reseed_ready <= 1'b1;
          else if (any_req)  idx <= winner;
        end
        SHIFT: begin
          lfsr      <= lfsr_step;
          acc       <= shift_in(acc, fb);
          cnt       <= cnt + CNT_W'(1);
          wrap_tick <= (lfsr_step == SEED);
          if (last_step) begin
            rnd_data  <= shift_in(acc, fb);
            rnd_valid <= 1'b1;
            gnt       <= NREQ'(1) << idx;
          end
        end
        DELIVER: begin
          ptr <= (idx == IDX_W'(NREQ - 1)) ? '0 : idx + IDX_W'(1);
        end
        RESEED: begin
          // An all-zero state would lock the LFSR up; fall back to SEED.
          lfsr <= (reseed_data == 17'd0) ? SEED : reseed_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Testbench for lfsr_rng_arbiter: scoreboard queue filled by the stimulus
// side from a behavioural model, drained by a monitor on rnd_valid/reseed_ready.
module tb_lfsr_rng_arbiter;

  localparam int NREQ = 4;
  localparam int WB   = 8;
  localparam int SEED = 'h0002B;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NREQ-1:0] req;
  logic          reseed_valid;
  logic [16:0]   reseed_data;
  logic          reseed_ready;
  logic [NREQ-1:0] gnt;
  logic          rnd_valid;
  logic [WB-1:0] rnd_data;
  logic          busy;
  logic          wrap_tick;

  lfsr_rng_arbiter #(.NREQ(NREQ), .WORD_BITS(WB), .SEED(17'h0002B)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .reseed_valid(reseed_valid),
    .reseed_data(reseed_data), .reseed_ready(reseed_ready), .gnt(gnt),
    .rnd_valid(rnd_valid), .rnd_data(rnd_data), .busy(busy), .wrap_tick(wrap_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit rs; int idx; int word; } exp_t;
  exp_t sb[$];
  int   gnt_cyc[$];
  int   word_log[$];
  int   errors = 0;
  int   checks = 0;
  int   wrap_cnt = 0;
  int   wrap_cyc = -1;

  // Reference model: LFSR state as a plain integer and round-robin pointer.
  int ms   = SEED;
  int mptr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_word();
    int s, w, b;
    s = ms; w = 0;
    for (int i = 0; i < WB; i++) begin
      b = ((s >> 16) ^ (s >> 13)) & 1;
      s = ((s << 1) | b) & 'h1FFFF;
      w = (w << 1) | b;
    end
    ms = s;
    return w;
  endfunction

  function automatic int pick(input int m, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (((m >> ((p + k) % NREQ)) & 1) != 0) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic void push_word(input int w);
    exp_t e;
    e.rs = 1'b0; e.idx = w; e.word = model_word();
    sb.push_back(e);
    mptr = (w + 1) % NREQ;
  endfunction

  function automatic void push_reseed(input int v);
    exp_t e;
    e.rs = 1'b1; e.idx = 0; e.word = 0;
    sb.push_back(e);
    ms = (v == 0) ? SEED : v;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  always @(negedge clk) begin
    exp_t e;
    if (wrap_tick) begin
      wrap_cnt++;
      wrap_cyc = cyc;
    end
    if (!rnd_valid && gnt != '0) chk("gnt_without_valid", 32'(gnt), 0);
    if (rnd_valid || reseed_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {30'd0, rnd_valid, reseed_ready}, 0);
      end else begin
        e = sb.pop_front();
        if (e.rs) begin
          chk("reseed_order", {30'd0, reseed_ready, rnd_valid}, 32'd2);
        end else begin
          chk("gnt", 32'(gnt), 32'(1) << e.idx);
          chk("rnd_data", 32'(rnd_data), 32'(e.word));
          chk("valid_alone", {31'd0, reseed_ready}, 0);
          gnt_cyc.push_back(cyc);
          word_log.push_back(int'(rnd_data));
        end
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 0);
  endtask

  task automatic do_reseed(input int v);
    int t0, k;
    wait_idle();
    t0 = cyc;
    reseed_valid = 1'b1;
    reseed_data  = 17'(v);
    push_reseed(v);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!reseed_ready && k < 20);
    reseed_valid = 1'b0;
    chk("reseed_latency", 32'(cyc - t0), 1);
  endtask

  // Hold req constant for n grants; checks latency, spacing and the busy gap.
  task automatic hold_req(input int mask, input int n, output int t0);
    int got, low, budget, base;
    wait_idle();
    base = gnt_cyc.size();
    t0 = cyc;
    for (int i = 0; i < n; i++) push_word(pick(mask, mptr));
    req = NREQ'(mask);
    got = 0; low = 0; budget = n * (WB + 4) + 20;
    while (got < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (!busy) low++;
      if (rnd_valid) begin
        got++;
        if (got == n) req = '0;
        if (got > 1) chk("busy_gap", 32'(low), 1);
        low = 0;
      end
    end
    req = '0;
    if (got < n) chk("hold_timeout", 32'(got), 32'(n));
    #1;
    if (gnt_cyc.size() >= base + n) begin
      chk("first_latency", 32'(gnt_cyc[base] - t0), WB + 1);
      for (int i = 1; i < n; i++)
        chk("grant_spacing", 32'(gnt_cyc[base + i] - gnt_cyc[base + i - 1]), WB + 2);
    end
  endtask

  // Raise a set of requests; each drops its bit when granted.
  task automatic batch(input int mask);
    int m, budget;
    wait_idle();
    m = mask;
    while (m != 0) begin
      int w;
      w = pick(m, mptr);
      push_word(w);
      m &= ~(1 << w);
    end
    req = NREQ'(mask);
    budget = NREQ * (WB + 4) + 20;
    while (req != '0 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (rnd_valid) req = req & ~gnt;
    end
    if (req != '0) chk("batch_timeout", 32'(req), 0);
    req = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {gnt, rnd_valid, rnd_data, reseed_ready, busy, wrap_tick}, 0);
    rst_n = 1'b1;
    ms = SEED;
    mptr = 0;
  endtask

  initial begin
    int t0, base, w0, k;
    rst_n = 1'b0; req = '0; reseed_valid = 1'b0; reseed_data = '0;
    repeat (2) @(negedge clk);
    apply_reset();

    // Two words from the reset seed on requester 0.
    base = word_log.size();
    hold_req(1, 2, t0);
    #1;
    if (word_log.size() >= base + 2) begin
      chk("first_word", 32'(word_log[base]), 32'h00);
      chk("second_word", 32'(word_log[base + 1]), 32'hB9);
    end else chk("first_words_missing", 32'(word_log.size() - base), 2);

    // Reset asserted in the 4th SHIFT cycle aborts the request.
    wait_idle();
    req = 4'b0001;
    repeat (4) @(negedge clk);
    req = '0;
    apply_reset();
    chk("abort_busy", {31'd0, busy}, 0);
    repeat (15) @(negedge clk);

    // All requesters held: full rotation starting from requester 0.
    base = word_log.size();
    hold_req(4'b1111, 5, t0);
    #1;
    if (word_log.size() > base) chk("post_reset_word", 32'(word_log[base]), 32'h00);

    // Zero reseed falls back to SEED.
    do_reseed(0);
    base = word_log.size();
    hold_req(1, 1, t0);
    #1;
    if (word_log.size() > base) chk("zero_reseed_word", 32'(word_log[base]), 32'h00);

    // Predecessor of SEED: one wrap_tick in the second SHIFT cycle, then none.
    do_reseed('h10015);
    w0 = wrap_cnt;
    hold_req(1, 1, t0);
    chk("wrap_count", 32'(wrap_cnt - w0), 1);
    chk("wrap_cycle", 32'(wrap_cyc - t0), 2);
    w0 = wrap_cnt;
    hold_req(1, 2000, t0);
    chk("no_second_wrap", 32'(wrap_cnt - w0), 0);

    // Reseed raised mid-SHIFT together with a request from requester 1.
    wait_idle();
    push_word(pick(1, mptr));
    req = 4'b0001;
    repeat (3) @(negedge clk);
    t0 = int'($urandom_range(1, 'h1FFFF));
    req = 4'b0011;
    reseed_valid = 1'b1;
    reseed_data = 17'(t0);
    push_reseed(t0);
    push_word(pick(2, mptr));
    k = 0;
    while ((req != '0 || reseed_valid) && k < 60) begin
      @(negedge clk);
      k++;
      if (reseed_ready) reseed_valid = 1'b0;
      if (rnd_valid) req = req & ~gnt;
    end
    if (req != '0 || reseed_valid) chk("midshift_timeout", {27'd0, req, reseed_valid}, 0);
    req = '0; reseed_valid = 1'b0;

    // Randomized traffic with occasional reseeds.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0)
        do_reseed(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 'h1FFFF)));
      batch(int'($urandom_range(1, 15)));
    end

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_rng_arbiter.md
# lfsr_rng_arbiter

Shares one 17-bit Fibonacci LFSR (x^17 + x^14 + 1, maximal length 131071) between NREQ requesters. Each grant returns a fresh WORD_BITS-bit random word built from consecutive feedback bits. Requesters are served round-robin. A reseed port reloads the LFSR at run time. The block sits between the LFSR datapath and the consumers (test-pattern generators, dither, noise injection), so the generator no longer has to be paused or reset per consumer.

## Interface
- NREQ, 4: number of requesters, 2..8.
- WORD_BITS, 8: feedback bits gathered per grant, 1..17.
- SEED, 17'h0002B: reset state; also replaces an all-zero reseed value.

- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  NREQ  request level per requester; hold until own gnt bit.
- reseed_valid  in  1  reseed request; hold until reseed_ready.
- reseed_data  in  17  new LFSR state.
- reseed_ready  out  1  one-cycle pulse: reseed applied.
- gnt  out  NREQ  one-hot, one-cycle pulse, coincident with rnd_valid.
- rnd_valid  out  1  one-cycle pulse: rnd_data valid.
- rnd_data  out  WORD_BITS  random word; holds its last value between grants.
- busy  out  1  high whenever the FSM is not in IDLE.
- wrap_tick  out  1  one-cycle pulse: LFSR state has just returned to SEED through a shift.

## Operation
- LFSR step: fb = s[16] ^ s[13]; s <= {s[15:0], fb}.
- The LFSR shifts only in the SHIFT state. It holds in every other state.
- IDLE behaviour:
  - reseed_valid has priority over req. If reseed_valid = 1, go to RESEED.
  - Otherwise, if any req bit is set, pick the winner: search upward from ptr, modulo NREQ; the first set bit wins.
  - Latch the winner as idx, clear the bit counter, go to SHIFT.
- SHIFT state:
  - One LFSR step per cycle.
  - Each step also shifts the capture register: acc <= {acc[WORD_BITS-2:0], fb}. The first bit ends up in the MSB.
  - After WORD_BITS steps, go to DELIVER.
- DELIVER state (one cycle):
  - Drive rnd_data = acc, rnd_valid = 1, gnt[idx] = 1.
  - Update ptr = (idx + 1) mod NREQ.
  - Go to IDLE.
- RESEED state (one cycle):
  - Load s = reseed_data, or SEED if reseed_data == 0 (prevents lock-up).
  - Pulse reseed_ready; ptr is unchanged.
  - Go to IDLE.
  - Reseeding never raises wrap_tick.
- If a requester drops req after arbitration, its word is still delivered with gnt. No cancellation.
- reseed_valid raised while busy waits until the next IDLE. A req pending at that point is served after the reseed, from the new state.
- req bits for the current idx seen during SHIFT/DELIVER are ignored. Arbitration happens only in IDLE.
- wrap_tick is registered: it goes high in the cycle after a SHIFT step whose next state equals SEED.
- Widths: the bit counter is clog2(WORD_BITS+1) bits; ptr and idx are clog2(NREQ) bits, wrapping at NREQ, not at a power of two.

## Timing
- Reset values: s = SEED, FSM = IDLE, ptr = 0, acc = 0. gnt, rnd_valid, rnd_data, reseed_ready, busy and wrap_tick are all 0.
- req sampled in IDLE at cycle t:
  - SHIFT occupies cycles t+1 .. t+WORD_BITS.
  - gnt and rnd_valid are high in cycle t+WORD_BITS+1.
  - Back in IDLE at t+WORD_BITS+2.
- Sustained throughput is one word per WORD_BITS+2 cycles (10 cycles with defaults).
- reseed_valid sampled in IDLE at t: reseed_ready is high in t+1; the new state is visible from t+2.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- rst_n low mid-SHIFT or mid-DELIVER: on the next edge, all state is restored to reset values, and no gnt or rnd_valid is issued for the aborted request.

## Test plan
- Reset, then req=0001 held through two grants → first rnd_data 0x00 (gnt=0001 at cycle 9 after sample), second 0xB9, 10 cycles later.
- req=1111 held constant → gnt sequence 0001, 0010, 0100, 1000, 0001, pulses exactly 10 cycles apart; busy low for exactly one cycle between words.
- Reseed with reseed_data=0, then req=0001 → reseed_ready one cycle after sample; state = SEED; rnd_data = 0x00.
- Reseed 17'h10015 (predecessor of SEED), then req=0001 → wrap_tick pulses once, in the second SHIFT cycle of that request; no further wrap_tick during the next 2000 words.
- reseed_valid asserted mid-SHIFT together with req=0010 → current word completes, then RESEED, then grant to requester 1 from the new state; reseed_ready precedes gnt.
- rst_n low for one cycle at the 4th SHIFT cycle → no gnt; all outputs 0; the next request returns 0x00 (seed restored).
